// File: rtl/l2k_pkg.sv
// Shared types and lane-steering helpers for the l2k memory arbiter.
package l2k_pkg;

  typedef logic [1:0] mem_size_t;
  localparam mem_size_t SIZE_BYTE = 2'd0;
  localparam mem_size_t SIZE_HALF = 2'd1;
  localparam mem_size_t SIZE_WORD = 2'd2;

  typedef logic [1:0] marb_state_t;
  localparam marb_state_t IDLE  = 2'd0;
  localparam marb_state_t ISSUE = 2'd1;
  localparam marb_state_t DONE  = 2'd2;

  // Byte offset of the access, forced to the natural alignment of its size.
  function automatic logic [1:0] lane_off(input logic [1:0] addr_lo, input mem_size_t size);
    case (size)
      SIZE_BYTE: lane_off = addr_lo;
      SIZE_HALF: lane_off = {addr_lo[1], 1'b0};
      default:   lane_off = 2'b00;
    endcase
  endfunction

  // Byte enables for an access of the given size at the given offset.
  function automatic logic [3:0] be_gen(input logic [1:0] addr_lo, input mem_size_t size);
    case (size)
      SIZE_BYTE: be_gen = 4'b0001 << lane_off(addr_lo, size);
      SIZE_HALF: be_gen = 4'b0011 << lane_off(addr_lo, size);
      default:   be_gen = 4'hF;
    endcase
  endfunction

  // Replicate right-justified write data across every lane it could land in.
  function automatic logic [31:0] wdata_rep(input logic [31:0] value, input mem_size_t size);
    case (size)
      SIZE_BYTE: wdata_rep = {4{value[7:0]}};
      SIZE_HALF: wdata_rep = {2{value[15:0]}};
      default:   wdata_rep = value;
    endcase
  endfunction

  // Pick the addressed lane out of a RAM word and zero-extend it.
  function automatic logic [31:0] rdata_ext(input logic [31:0] data, input logic [1:0] addr_lo,
                                             input mem_size_t size);
    logic [31:0] shifted;
    shifted = data >> {lane_off(addr_lo, size), 3'b000};
    case (size)
      SIZE_BYTE: rdata_ext = {24'h0, shifted[7:0]};
      SIZE_HALF: rdata_ext = {16'h0, shifted[15:0]};
      default:   rdata_ext = data;
    endcase
  endfunction

endpackage

// File: rtl/l2k_marb_if.sv
// RAM port plus per-client request/response bundle for the memory arbiter.
interface l2k_marb_if #(
  parameter int unsigned NUM_CLIENTS = 4
);
  logic [31:0]               ram_addr;
  logic [31:0]               ram_data_in;
  logic [31:0]               ram_data_out;
  logic [3:0]                ram_be;
  logic                      ram_rdy;
  logic                      ram_we;
  logic                      ram_ce;
  logic [32*NUM_CLIENTS-1:0] client_read_addr;
  logic [2*NUM_CLIENTS-1:0]  client_read_size;
  logic [NUM_CLIENTS-1:0]    client_read_enable;
  logic [32*NUM_CLIENTS-1:0] client_read_value;
  logic [32*NUM_CLIENTS-1:0] client_read_addr_in;
  logic [NUM_CLIENTS-1:0]    client_read_rdy;
  logic [32*NUM_CLIENTS-1:0] client_write_addr;
  logic [32*NUM_CLIENTS-1:0] client_write_value;
  logic [2*NUM_CLIENTS-1:0]  client_write_size;
  logic [NUM_CLIENTS-1:0]    client_write_enable;
  logic [NUM_CLIENTS-1:0]    client_write_rdy;
  logic [NUM_CLIENTS-1:0]    client_err;

  modport master (
    output ram_addr, ram_data_out, ram_be, ram_we, ram_ce,
    input  ram_data_in, ram_rdy,
    input  client_read_addr, client_read_size, client_read_enable,
    output client_read_value, client_read_addr_in, client_read_rdy,
    input  client_write_addr, client_write_value, client_write_size, client_write_enable,
    output client_write_rdy, client_err
  );

  modport slave (
    input  ram_addr, ram_data_out, ram_be, ram_we, ram_ce,
    output ram_data_in, ram_rdy,
    output client_read_addr, client_read_size, client_read_enable,
    input  client_read_value, client_read_addr_in, client_read_rdy,
    output client_write_addr, client_write_value, client_write_size, client_write_enable,
    input  client_write_rdy, client_err
  );
endinterface

// File: rtl/l2k_rr_arb.sv
// Combinational round-robin picker: first pending requester at or above ptr, wrapping.
module l2k_rr_arb #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     pending,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant_oh_c,
  output logic [IDX_W-1:0] grant_idx_c,
  output logic             grant_valid_c
);

  logic [31:0] cand;

  // Walk the clients starting at ptr and take the first one asking.
  always_comb begin
    grant_oh_c    = '0;
    grant_idx_c   = '0;
    grant_valid_c = 1'b0;
    cand          = '0;
    for (int unsigned i = 0; i < N; i++) begin
      cand = (32'(ptr) + i) % N;
      if (!grant_valid_c && pending[IDX_W'(cand)]) begin
        grant_valid_c            = 1'b1;
        grant_idx_c              = IDX_W'(cand);
        grant_oh_c[IDX_W'(cand)] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/l2k_marb.sv
// Multi-client RAM arbiter: round-robin between clients, writes before reads,
// sub-word lane steering and per-access timeout.
module l2k_marb
  import l2k_pkg::*;
#(
  parameter int unsigned NUM_CLIENTS    = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  l2k_marb_if.master  bus
);

  localparam int unsigned IDX_W = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  marb_state_t state, state_nxt;

  logic [IDX_W-1:0]       rr_ptr;
  logic [NUM_CLIENTS-1:0] pending;
  logic [NUM_CLIENTS-1:0] gnt_oh_c;
  logic [IDX_W-1:0]       gnt_idx_c;
  logic                   gnt_valid_c;
  logic                   gnt_wr_c;
  logic [31:0]            req_addr_c;
  mem_size_t              req_size_c;
  logic [31:0]            req_wdata_c;

  logic [IDX_W-1:0]       cur_idx;
  logic                   cur_wr;
  logic [31:0]            cur_addr;
  mem_size_t              cur_size;
  logic [CNT_W-1:0]       tmo_cnt;
  logic                   tmo_hit_c;
  logic                   access_end_c;

  logic [31:0]               ram_addr_q;
  logic [31:0]               ram_data_out_q;
  logic [3:0]                ram_be_q;
  logic                      ram_we_q;
  logic                      ram_ce_q;
  logic [32*NUM_CLIENTS-1:0] read_value_q;
  logic [32*NUM_CLIENTS-1:0] read_addr_in_q;
  logic [NUM_CLIENTS-1:0]    read_rdy_q;
  logic [NUM_CLIENTS-1:0]    write_rdy_q;
  logic [NUM_CLIENTS-1:0]    err_q;

  assign pending = bus.client_read_enable | bus.client_write_enable;

  l2k_rr_arb #(
    .N     (NUM_CLIENTS),
    .IDX_W (IDX_W)
  ) u_arb (
    .pending       (pending),
    .ptr           (rr_ptr),
    .grant_oh_c    (gnt_oh_c),
    .grant_idx_c   (gnt_idx_c),
    .grant_valid_c (gnt_valid_c)
  );

  assign gnt_wr_c     = |(gnt_oh_c & bus.client_write_enable);
  assign tmo_hit_c    = (tmo_cnt == TMO_LAST);
  assign access_end_c = bus.ram_rdy || tmo_hit_c;

  // Select the granted client's fields; a pending write wins over its read.
  always_comb begin
    req_addr_c  = gnt_wr_c ? bus.client_write_addr[32*gnt_idx_c +: 32]
                           : bus.client_read_addr[32*gnt_idx_c +: 32];
    req_size_c  = gnt_wr_c ? bus.client_write_size[2*gnt_idx_c +: 2]
                           : bus.client_read_size[2*gnt_idx_c +: 2];
    req_wdata_c = wdata_rep(bus.client_write_value[32*gnt_idx_c +: 32], req_size_c);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (gnt_valid_c) state_nxt = ISSUE;
      ISSUE:   if (access_end_c) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Grant latch, RAM drive, timeout count and client completion pulses.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rr_ptr         <= '0;
      cur_idx        <= '0;
      cur_wr         <= 1'b0;
      cur_addr       <= '0;
      cur_size       <= SIZE_BYTE;
      tmo_cnt        <= '0;
      ram_addr_q     <= '0;
      ram_data_out_q <= '0;
      ram_be_q       <= '0;
      ram_we_q       <= 1'b0;
      ram_ce_q       <= 1'b0;
      read_value_q   <= '0;
      read_addr_in_q <= '0;
      read_rdy_q     <= '0;
      write_rdy_q    <= '0;
      err_q          <= '0;
    end else begin
      read_rdy_q  <= '0;
      write_rdy_q <= '0;
      err_q       <= '0;
      case (state)
        IDLE: begin
          if (gnt_valid_c) begin
            cur_idx        <= gnt_idx_c;
            cur_wr         <= gnt_wr_c;
            cur_addr       <= req_addr_c;
            cur_size       <= req_size_c;
            tmo_cnt        <= '0;
            rr_ptr         <= (gnt_idx_c == IDX_W'(NUM_CLIENTS - 1)) ? '0
                                                                      : gnt_idx_c + IDX_W'(1);
            ram_ce_q       <= 1'b1;
            ram_we_q       <= gnt_wr_c;
            ram_addr_q     <= {req_addr_c[31:2], 2'b00};
            ram_be_q       <= be_gen(req_addr_c[1:0], req_size_c);
            ram_data_out_q <= gnt_wr_c ? req_wdata_c : '0;
          end
        end
        ISSUE: begin
          if (access_end_c) begin
            ram_ce_q       <= 1'b0;
            err_q[cur_idx] <= !bus.ram_rdy;
            if (cur_wr) begin
              write_rdy_q[cur_idx] <= 1'b1;
            end else begin
              read_rdy_q[cur_idx]            <= 1'b1;
              read_addr_in_q[32*cur_idx +: 32] <= cur_addr;
              read_value_q[32*cur_idx +: 32] <= bus.ram_rdy
                  ? rdata_ext(bus.ram_data_in, cur_addr[1:0], cur_size)
                  : 32'hFFFF_FFFF;
            end
          end else begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.ram_addr            = ram_addr_q;
  assign bus.ram_data_out        = ram_data_out_q;
  assign bus.ram_be              = ram_be_q;
  assign bus.ram_we              = ram_we_q;
  assign bus.ram_ce              = ram_ce_q;
  assign bus.client_read_value   = read_value_q;
  assign bus.client_read_addr_in = read_addr_in_q;
  assign bus.client_read_rdy     = read_rdy_q;
  assign bus.client_write_rdy    = write_rdy_q;
  assign bus.client_err          = err_q;

endmodule

// File: tb/tb_l2k_marb.sv
// Bench for l2k_marb: directed scenarios plus random batches against a
// transaction-level model of the arbitration and lane rules.
module tb_l2k_marb;

  localparam int unsigned NC  = 4;
  localparam int unsigned TMO = 4;

  typedef struct {
    int          c;
    bit          wr;
    bit          err;
    logic [31:0] val;
    logic [31:0] ain;
    int          cyc;
  } ev_t;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    bit          we;
    logic [31:0] data;
  } acc_t;

  logic clk;
  logic rst;

  l2k_marb_if #(.NUM_CLIENTS(NC)) bus ();

  l2k_marb #(
    .NUM_CLIENTS    (NC),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [32*NC-1:0] raddr_v, waddr_v, wval_v;
  logic [2*NC-1:0]  rsize_v, wsize_v;
  logic [NC-1:0]    ren_v, wen_v;
  logic             ram_rdy_r;
  bit               ovr_en;
  logic [31:0]      ovr_val;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc = 0;
  int ram_lat = 0;
  int ce_cnt = 0;
  int ce_steps = 0;
  int mdl_ptr = 0;
  bit ce_prev = 0;
  bit auto_drop = 1;
  acc_t last_acc;
  ev_t  ev_q[$];
  acc_t acc_q[$];

  // Deterministic RAM contents as a function of word address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a ^ 32'h5A5A_C3C3) * 32'h9E37_79B1 + 32'h0BAD_F00D;
  endfunction

  function automatic logic [3:0] exp_be(input logic [31:0] a, input logic [1:0] sz);
    case (sz)
      2'd0:    return 4'b0001 << a[1:0];
      2'd1:    return a[1] ? 4'b1100 : 4'b0011;
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [31:0] v, input logic [1:0] sz);
    case (sz)
      2'd0:    return 32'(v[7:0]) * 32'h0101_0101;
      2'd1:    return 32'(v[15:0]) * 32'h0001_0001;
      default: return v;
    endcase
  endfunction

  function automatic logic [31:0] exp_rval(input logic [31:0] w, input logic [31:0] a,
                                           input logic [1:0] sz);
    int sh;
    case (sz)
      2'd0: begin
        sh = 8 * int'(a[1:0]);
        return (w >> sh) & 32'h0000_00FF;
      end
      2'd1: begin
        sh = a[1] ? 16 : 0;
        return (w >> sh) & 32'h0000_FFFF;
      end
      default: return w;
    endcase
  endfunction

  assign bus.client_read_addr    = raddr_v;
  assign bus.client_read_size    = rsize_v;
  assign bus.client_read_enable  = ren_v;
  assign bus.client_write_addr   = waddr_v;
  assign bus.client_write_value  = wval_v;
  assign bus.client_write_size   = wsize_v;
  assign bus.client_write_enable = wen_v;
  assign bus.ram_rdy             = ram_rdy_r;
  assign bus.ram_data_in         = ovr_en ? ovr_val : mem_word(bus.ram_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One cycle: sample at negedge, record RAM accesses and completions, drive ram_rdy.
  task automatic step();
    acc_t a;
    ev_t  e;
    bit   moved;
    @(negedge clk);
    cyc++;
    if (bus.ram_ce === 1'b1) begin
      ce_steps++;
      a.addr = bus.ram_addr;
      a.be   = bus.ram_be;
      a.we   = bus.ram_we;
      a.data = bus.ram_data_out;
      if (!ce_prev) begin
        acc_q.push_back(a);
        last_acc = a;
      end else begin
        moved = (a.addr !== last_acc.addr) || (a.be !== last_acc.be) ||
                (a.we != last_acc.we) || (a.data !== last_acc.data);
        check("ram_hold", 32'(moved), 32'd0);
      end
      ram_rdy_r = (ce_cnt == ram_lat);
      ce_cnt++;
    end else begin
      ram_rdy_r = 1'b0;
      ce_cnt    = 0;
    end
    ce_prev = (bus.ram_ce === 1'b1);
    for (int c = 0; c < int'(NC); c++) begin
      if (bus.client_read_rdy[c] === 1'b1 || bus.client_write_rdy[c] === 1'b1) begin
        e.c   = c;
        e.wr  = (bus.client_write_rdy[c] === 1'b1);
        e.err = (bus.client_err[c] === 1'b1);
        e.val = bus.client_read_value[32*c +: 32];
        e.ain = bus.client_read_addr_in[32*c +: 32];
        e.cyc = cyc;
        ev_q.push_back(e);
        if (auto_drop) begin
          if (e.wr) wen_v[c] = 1'b0;
          else      ren_v[c] = 1'b0;
        end
      end
    end
  endtask

  // Predict the whole service order from the current requests, run it, compare.
  task automatic run_batch(input int lat);
    logic [NC-1:0] pw, pr;
    logic [31:0]   addr;
    logic [1:0]    sz;
    int            p, c, n;
    ev_t           e;
    acc_t          a;
    ev_t           xev[$];
    acc_t          xacc[$];
    pw = wen_v;
    pr = ren_v;
    p  = mdl_ptr;
    c  = 0;
    while ((pw | pr) != '0) begin
      for (int k = 0; k < int'(NC); k++) begin
        c = (p + k) % int'(NC);
        if (pw[c] || pr[c]) break;
      end
      addr   = pw[c] ? waddr_v[32*c +: 32] : raddr_v[32*c +: 32];
      sz     = pw[c] ? wsize_v[2*c +: 2] : rsize_v[2*c +: 2];
      a.addr = addr & ~32'h3;
      a.be   = exp_be(addr, sz);
      a.we   = pw[c];
      a.data = exp_wdata(wval_v[32*c +: 32], sz);
      e.c    = c;
      e.wr   = pw[c];
      e.err  = (lat >= int'(TMO));
      e.ain  = addr;
      e.val  = e.err ? 32'hFFFF_FFFF : exp_rval(ovr_en ? ovr_val : mem_word(a.addr), addr, sz);
      e.cyc  = 0;
      if (pw[c]) pw[c] = 1'b0;
      else       pr[c] = 1'b0;
      p = (c + 1) % int'(NC);
      xev.push_back(e);
      xacc.push_back(a);
    end
    mdl_ptr = p;
    ev_q.delete();
    acc_q.delete();
    ram_lat   = lat;
    ce_steps  = 0;
    start_cyc = cyc;
    n = 0;
    while ((ren_v | wen_v) != '0 && n < 300) begin
      step();
      n++;
    end
    repeat (2) step();
    check("batch_done", 32'(n < 300), 32'd1);
    check("n_events", 32'(ev_q.size()), 32'(xev.size()));
    check("n_access", 32'(acc_q.size()), 32'(xacc.size()));
    for (int i = 0; i < xev.size(); i++) begin
      if (i < ev_q.size() && i < acc_q.size()) begin
        check("client", 32'(ev_q[i].c), 32'(xev[i].c));
        check("is_write", 32'(ev_q[i].wr), 32'(xev[i].wr));
        check("err", 32'(ev_q[i].err), 32'(xev[i].err));
        check("ram_addr", acc_q[i].addr, xacc[i].addr);
        check("ram_be", 32'(acc_q[i].be), 32'(xacc[i].be));
        check("ram_we", 32'(acc_q[i].we), 32'(xacc[i].we));
        if (xev[i].wr) begin
          check("ram_wdata", acc_q[i].data, xacc[i].data);
        end else begin
          check("read_value", ev_q[i].val, xev[i].val);
          check("read_addr_in", ev_q[i].ain, xev[i].ain);
        end
      end
    end
  endtask

  task automatic do_reset();
    rst   = 1'b0;
    ren_v = '0;
    wen_v = '0;
    repeat (2) step();
    rst     = 1'b1;
    mdl_ptr = 0;
  endtask

  initial begin
    rst       = 1'b0;
    raddr_v   = '0;
    waddr_v   = '0;
    wval_v    = '0;
    rsize_v   = '0;
    wsize_v   = '0;
    ren_v     = '0;
    wen_v     = '0;
    ram_rdy_r = 1'b0;
    ovr_en    = 1'b0;
    ovr_val   = '0;

    // Reset values.
    repeat (3) step();
    check("rst_ce", 32'(bus.ram_ce), 32'd0);
    check("rst_we", 32'(bus.ram_we), 32'd0);
    check("rst_be", 32'(bus.ram_be), 32'd0);
    check("rst_addr", bus.ram_addr, 32'd0);
    check("rst_wdata", bus.ram_data_out, 32'd0);
    check("rst_rrdy", 32'(bus.client_read_rdy), 32'd0);
    check("rst_wrdy", 32'(bus.client_write_rdy), 32'd0);
    check("rst_err", 32'(bus.client_err), 32'd0);
    for (int c = 0; c < int'(NC); c++) begin
      check("rst_rval", bus.client_read_value[32*c +: 32], 32'd0);
      check("rst_ain", bus.client_read_addr_in[32*c +: 32], 32'd0);
    end
    rst = 1'b1;
    step();

    // Client 2 word read, RAM ready on the first ISSUE cycle.
    ovr_en  = 1'b1;
    ovr_val = 32'hDEAD_BEEF;
    raddr_v[64 +: 32] = 32'h0000_0100;
    rsize_v[4 +: 2]   = 2'd2;
    ren_v[2]          = 1'b1;
    run_batch(0);
    if (ev_q.size() > 0 && acc_q.size() > 0) begin
      check("t1_latency", 32'(ev_q[0].cyc - start_cyc), 32'd2);
      check("t1_value", ev_q[0].val, 32'hDEAD_BEEF);
      check("t1_addr_in", ev_q[0].ain, 32'h0000_0100);
      check("t1_be", 32'(acc_q[0].be), 32'hF);
      check("t1_we", 32'(acc_q[0].we), 32'd0);
    end
    ovr_en = 1'b0;

    // All clients hold reads continuously: strict rotation from pointer 0.
    do_reset();
    for (int c = 0; c < int'(NC); c++) begin
      raddr_v[32*c +: 32] = 32'(c * 16);
      rsize_v[2*c +: 2]   = 2'd2;
    end
    ev_q.delete();
    ram_lat   = 0;
    auto_drop = 0;
    ren_v     = '1;
    repeat (48) step();
    ren_v     = '0;
    auto_drop = 1;
    repeat (3) step();
    check("rr_count", 32'(ev_q.size()), 32'd16);
    for (int k = 0; k < ev_q.size(); k++) begin
      check("rr_order", 32'(ev_q[k].c), 32'(k % int'(NC)));
      check("rr_err", 32'(ev_q[k].err), 32'd0);
    end

    // Client 1 byte write then byte read at 0x203.
    waddr_v[32 +: 32] = 32'h0000_0203;
    wval_v[32 +: 32]  = 32'h1234_56A5;
    wsize_v[2 +: 2]   = 2'd0;
    wen_v[1]          = 1'b1;
    run_batch(0);
    if (acc_q.size() > 0) begin
      check("t3_addr", acc_q[0].addr, 32'h0000_0200);
      check("t3_be", 32'(acc_q[0].be), 32'b1000);
      check("t3_wdata", acc_q[0].data, 32'hA5A5_A5A5);
      check("t3_we", 32'(acc_q[0].we), 32'd1);
    end
    ovr_en  = 1'b1;
    ovr_val = 32'h1234_5678;
    raddr_v[32 +: 32] = 32'h0000_0203;
    rsize_v[2 +: 2]   = 2'd0;
    ren_v[1]          = 1'b1;
    run_batch(0);
    if (ev_q.size() > 0) check("t3_rval", ev_q[0].val, 32'h0000_0012);
    ovr_en = 1'b0;

    // Client 0 write+read with client 3 read pending.
    do_reset();
    waddr_v[0 +: 32]  = 32'h0000_0010;
    wval_v[0 +: 32]   = 32'hCAFE_F00D;
    wsize_v[0 +: 2]   = 2'd2;
    raddr_v[0 +: 32]  = 32'h0000_0022;
    rsize_v[0 +: 2]   = 2'd1;
    raddr_v[96 +: 32] = 32'h0000_0031;
    rsize_v[6 +: 2]   = 2'd0;
    wen_v[0] = 1'b1;
    ren_v[0] = 1'b1;
    ren_v[3] = 1'b1;
    run_batch(1);
    if (ev_q.size() == 3) begin
      check("t4_first", {ev_q[0].wr, 31'(ev_q[0].c)}, {1'b1, 31'd0});
      check("t4_mid", {ev_q[1].wr, 31'(ev_q[1].c)}, {1'b0, 31'd3});
      check("t4_last", {ev_q[2].wr, 31'(ev_q[2].c)}, {1'b0, 31'd0});
    end

    // Timeout: RAM never ready, then a normal access.
    raddr_v[64 +: 32] = 32'h0000_0040;
    rsize_v[4 +: 2]   = 2'd2;
    ren_v[2]          = 1'b1;
    run_batch(99);
    check("t5_ce_cycles", 32'(ce_steps), 32'(TMO));
    if (ev_q.size() > 0) begin
      check("t5_err", 32'(ev_q[0].err), 32'd1);
      check("t5_rval", ev_q[0].val, 32'hFFFF_FFFF);
    end
    ren_v[2] = 1'b1;
    run_batch(0);
    if (ev_q.size() > 0) check("t5_recover_err", 32'(ev_q[0].err), 32'd0);

    // Reset during ISSUE.
    raddr_v[32 +: 32] = 32'h0000_0080;
    rsize_v[2 +: 2]   = 2'd2;
    ren_v[1]          = 1'b1;
    ram_lat           = 99;
    ev_q.delete();
    step();
    check("t6_ce_before", 32'(bus.ram_ce), 32'd1);
    rst      = 1'b0;
    ren_v[1] = 1'b0;
    step();
    check("t6_ce_after", 32'(bus.ram_ce), 32'd0);
    step();
    check("t6_no_pulse", 32'(ev_q.size()), 32'd0);
    rst     = 1'b1;
    mdl_ptr = 0;
    step();
    raddr_v[96 +: 32] = 32'h0000_0104;
    rsize_v[6 +: 2]   = 2'd1;
    ren_v[3]          = 1'b1;
    run_batch(0);
    if (ev_q.size() > 0) check("t6_client3", 32'(ev_q[0].c), 32'd3);

    // Random batches against the model.
    for (int b = 0; b < 40; b++) begin
      for (int c = 0; c < int'(NC); c++) begin
        logic [1:0] r;
        r = 2'($urandom_range(0, 3));
        raddr_v[32*c +: 32] = $urandom;
        waddr_v[32*c +: 32] = $urandom;
        wval_v[32*c +: 32]  = $urandom;
        rsize_v[2*c +: 2]   = 2'($urandom_range(0, 3));
        wsize_v[2*c +: 2]   = 2'($urandom_range(0, 3));
        ren_v[c] = r[0];
        wen_v[c] = r[1];
      end
      run_batch(int'($urandom_range(0, 5)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/l2k_marb.md
Name: l2k_marb

Overview:
Parameterised multi-client memory arbiter. It replaces the single-client scheduler so that NUM_CORES l2k_core instances can share one external RAM port. Each client has one read and one write request channel. Arbitration between clients is round-robin; within a client, writes take priority over reads. The block also does sub-word lane steering and per-transaction timeout detection. It sits between the core array and the top-level RAM pins of l2k_cpu.

Parameters:
NUM_CLIENTS, 4, number of client ports (1..8).
TIMEOUT_CYCLES, 255, cycles ce may wait for ram_rdy before the transaction is aborted (1..65535).

Ports:
clk  input  1  system clock.
rst  input  1  synchronous, active-low reset.
ram_addr  output  32  word-aligned RAM address (bits [1:0] always 0).
ram_data_in  input  32  RAM read data.
ram_data_out  output  32  RAM write data, lane-replicated.
ram_be  output  4  byte enables (bit n = byte lane n).
ram_rdy  input  1  RAM completes the current access.
ram_we  output  1  1 = write, 0 = read.
ram_ce  output  1  access active.
client_read_addr  input  32*NUM_CLIENTS  read address per client.
client_read_size  input  2*NUM_CLIENTS  0 = byte, 1 = half, 2 = word, 3 = word.
client_read_enable  input  NUM_CLIENTS  read request, level.
client_read_value  output  32*NUM_CLIENTS  zero-extended read result.
client_read_addr_in  output  32*NUM_CLIENTS  address the returned value belongs to.
client_read_rdy  output  NUM_CLIENTS  one-cycle read-done pulse.
client_write_addr  input  32*NUM_CLIENTS  write address.
client_write_value  input  32*NUM_CLIENTS  write data, right-justified.
client_write_size  input  2*NUM_CLIENTS  same encoding as the read size.
client_write_enable  input  NUM_CLIENTS  write request, level.
client_write_rdy  output  NUM_CLIENTS  one-cycle write-done pulse.
client_err  output  NUM_CLIENTS  one-cycle timeout pulse, coincident with the rdy pulse of the aborted access.

Behaviour:
- Reset (rst == 0 at a clk edge):
  - FSM goes to IDLE; the round-robin pointer goes to 0; the timeout counter clears.
  - ram_ce, ram_we, ram_be, ram_addr, ram_data_out are 0.
  - All client_*_rdy and client_err are 0; all client_read_value and client_read_addr_in are 0.
  - Reset asserted mid-transaction drops ce on the next edge; no rdy pulse is generated.
- FSM states: IDLE -> ISSUE -> DONE -> IDLE.
- IDLE:
  - A client is pending if its write_enable or read_enable is 1.
  - Grant goes to the first pending client at or after the pointer, searching upward with wrap-around.
  - In the granted client, a pending write wins over a pending read.
  - Address, size, data and direction are latched; the FSM moves to ISSUE.
  - The pointer becomes grant+1 mod NUM_CLIENTS.
  - With no request pending, the FSM stays in IDLE and the pointer is unchanged.
- ISSUE:
  - ram_ce = 1; ram_addr, ram_we, ram_be and ram_data_out are held stable from the first ISSUE cycle.
  - The counter increments each cycle. When ram_rdy is sampled 1, read data is captured and the FSM moves to DONE.
  - If the counter reaches TIMEOUT_CYCLES without ram_rdy, the FSM moves to DONE with the error flag set; read value = 32'hFFFFFFFF.
- DONE:
  - ram_ce = 0.
  - The granted client's read_rdy or write_rdy pulses for exactly this cycle, plus client_err if the access timed out.
  - read_value and read_addr_in are updated this cycle and held until that client's next read completes.
  - Next state is IDLE.
- Minimum latency, request to rdy pulse: IDLE grant edge (t), ISSUE with ram_rdy at t+1, DONE pulse at t+2. That is 3 cycles from the enable being sampled.
- Clients hold enable and their fields until the rdy pulse.
  - Changes after grant are ignored; the latched transaction completes.
  - An enable still high in the cycle after DONE is treated as a new request.
- Lane steering: the offset is addr[1:0], forced aligned by size.
  - Half: offset = {addr[1], 0}.
  - Word: offset = 0.
  - be: byte = 1 << offset; half = 2'b11 << offset; word = 4'hF.
  - Write data: byte replicated to all 4 lanes; half replicated to both halves.
  - Read value: lane selected by offset and zero-extended.
  - read_addr_in returns the original unmasked address.
- A client asserting read and write together gets its write done first; the read is granted on that client's next turn.
- NUM_CLIENTS = 1 degenerates to write-before-read with no fairness change.

Decomposition:
- Package l2k_pkg holds:
  - typedef mem_size_t (2-bit) with constants SIZE_BYTE, SIZE_HALF, SIZE_WORD.
  - typedef marb_state_t with IDLE, ISSUE, DONE.
- Sub-module l2k_rr_arb (parameter N): pending vector and pointer in, one-hot grant plus grant index out. Purely combinational; the pointer register lives in l2k_marb.
- Lane steering is functions in l2k_pkg: be_gen, wdata_rep, rdata_ext.

Test Plan:
1. NUM_CLIENTS=4, client 2 reads word 0x100, RAM returns 0xDEADBEEF with ram_rdy at the first ISSUE cycle -> client_read_rdy[2] pulses at cycle t+2, read_value[2]=0xDEADBEEF, read_addr_in[2]=0x100, ram_be=4'hF, ram_we=0.
2. Clients 0..3 all hold read_enable continuously, RAM always ready -> grant order 0,1,2,3,0; each client receives exactly one rdy per 3 cycles × 4.
3. Client 1 writes byte 0xA5 to addr 0x203 -> ram_addr=0x200, ram_be=4'b1000, ram_data_out=0xA5A5A5A5, ram_we=1; client 1 byte read of 0x203 with RAM data 0x12345678 -> read_value=0x00000012.
4. Client 0 asserts write and read together -> write completes first, read completes on client 0's next turn; with client 3 also pending, client 3 is serviced between them.
5. TIMEOUT_CYCLES=4, ram_rdy held 0 -> ram_ce high for 4 cycles, then client_err and read_rdy pulse together with read_value=0xFFFFFFFF; the next request proceeds normally.
6. Reset pulled low during ISSUE -> ram_ce=0 next cycle, no rdy pulse, pointer=0; the first post-reset request from client 3 is granted.
